// File: rtl/otter_branch_predictor.sv
// -----------------------------------------------------------------------------
// otter_branch_predictor
//
// Direct-mapped branch target buffer with per-entry saturating direction
// counters for the pipelined OTTER core.
//
//   * Fetch side: the PC being fetched is looked up combinationally. The
//     predicted next PC feeds the PC-source mux as an extra input, so taken
//     branches that hit in the table no longer cost a flush.
//   * Execute side: every resolved BRANCH/JAL/JALR is reported on the update
//     port. The update trains the table and is compared against the
//     prediction that travelled down the pipe with the instruction.
//
// Address split (fetch_pc_i and upd_pc_i alike):
//   [1:0]                            ignored (instructions are word aligned)
//   [IDX_BITS+1:2]                   table index
//   [IDX_BITS+TAG_BITS+1:IDX_BITS+2] tag
//   upper bits                       not stored (aliasing is tolerated)
//
// Ports
//   clk_i                  clock; all state changes on the rising edge
//   reset_i                synchronous, active-high reset
//   fetch_pc_i      [31:0] PC being fetched this cycle
//   pred_hit_o             valid entry with a matching tag
//   pred_taken_o           predicted redirect
//   pred_target_o   [31:0] predicted next PC (target or fetch_pc_i + 4)
//   upd_valid_i            a resolved control-flow instruction this cycle
//   upd_pc_i        [31:0] PC of that instruction
//   upd_is_jump_i          1 = JAL/JALR (always taken), 0 = conditional branch
//   upd_taken_i            actual direction
//   upd_target_i    [31:0] actual target (meaningful when taken)
//   upd_pred_taken_i       pred_taken_o that accompanied the instruction
//   upd_pred_target_i[31:0] pred_target_o that accompanied the instruction
//   mispredict_o           combinational: resolved outcome differs from prediction
//   perf_updates_o         saturating count of cycles with upd_valid_i
//   perf_mispredicts_o     saturating count of cycles with mispredict_o
// -----------------------------------------------------------------------------
module otter_branch_predictor #(
    parameter int IDX_BITS  = 6,
    parameter int TAG_BITS  = 8,
    parameter int CTR_BITS  = 2,
    parameter int PERF_BITS = 32
) (
    input  logic                 clk_i,
    input  logic                 reset_i,

    // Fetch-stage lookup
    input  logic [31:0]          fetch_pc_i,
    output logic                 pred_hit_o,
    output logic                 pred_taken_o,
    output logic [31:0]          pred_target_o,

    // Execute-stage update
    input  logic                 upd_valid_i,
    input  logic [31:0]          upd_pc_i,
    input  logic                 upd_is_jump_i,
    input  logic                 upd_taken_i,
    input  logic [31:0]          upd_target_i,
    input  logic                 upd_pred_taken_i,
    input  logic [31:0]          upd_pred_target_i,
    output logic                 mispredict_o,

    // Performance counters
    output logic [PERF_BITS-1:0] perf_updates_o,
    output logic [PERF_BITS-1:0] perf_mispredicts_o
);

    // -------------------------------------------------------------------------
    // Derived constants
    // -------------------------------------------------------------------------
    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int IDX_LSB = 2;
    localparam int IDX_MSB = IDX_BITS + 1;
    localparam int TAG_LSB = IDX_BITS + 2;
    localparam int TAG_MSB = IDX_BITS + TAG_BITS + 1;

    localparam logic [CTR_BITS-1:0]  CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0]  CTR_MIN  = '0;
    // Newly allocated entries start weakly taken: MSB set, all else clear.
    localparam logic [CTR_BITS-1:0]  CTR_WEAK = CTR_BITS'(1 << (CTR_BITS - 1));
    localparam logic [PERF_BITS-1:0] PERF_MAX = '1;

    // -------------------------------------------------------------------------
    // Table storage
    // -------------------------------------------------------------------------
    typedef struct packed {
        logic [TAG_BITS-1:0] tag;
        logic                is_jump;
        logic [CTR_BITS-1:0] ctr;
        logic [31:0]         target;
    } entry_t;

    // NOTE: only the valid bits are reset. The entry payload is a plain memory
    // with no reset so it can map onto RAM; its contents are meaningless until
    // the matching valid bit is set, and every read is qualified by it.
    entry_t              entry_q [ENTRIES];
    logic [ENTRIES-1:0]  valid_q;
    logic [ENTRIES-1:0]  valid_d;

    logic [PERF_BITS-1:0] perf_updates_q;
    logic [PERF_BITS-1:0] perf_updates_d;
    logic [PERF_BITS-1:0] perf_mispredicts_q;
    logic [PERF_BITS-1:0] perf_mispredicts_d;

    // -------------------------------------------------------------------------
    // Fetch-side lookup (combinational, reads the pre-update table)
    // -------------------------------------------------------------------------
    logic [IDX_BITS-1:0] fetch_idx;
    logic [TAG_BITS-1:0] fetch_tag;
    entry_t              fetch_entry;
    logic                fetch_valid;

    assign fetch_idx   = fetch_pc_i[IDX_MSB:IDX_LSB];
    assign fetch_tag   = fetch_pc_i[TAG_MSB:TAG_LSB];
    assign fetch_entry = entry_q[fetch_idx];
    assign fetch_valid = valid_q[fetch_idx];

    // There is deliberately no bypass from the update port: an update to the
    // index being fetched becomes visible on the following cycle.
    always_comb begin
        pred_hit_o    = fetch_valid && (fetch_entry.tag == fetch_tag);
        pred_taken_o  = pred_hit_o && (fetch_entry.is_jump || fetch_entry.ctr[CTR_BITS-1]);
        pred_target_o = pred_taken_o ? fetch_entry.target : (fetch_pc_i + 32'd4);
    end

    // -------------------------------------------------------------------------
    // Mispredict detection
    // -------------------------------------------------------------------------
    // A direction mismatch is always a mispredict; a correctly predicted taken
    // transfer still mispredicts if it went somewhere other than predicted.
    // This stays live during reset: it depends only on the update inputs.
    assign mispredict_o = upd_valid_i &&
                          ((upd_taken_i != upd_pred_taken_i) ||
                           (upd_taken_i && (upd_target_i != upd_pred_target_i)));

    // -------------------------------------------------------------------------
    // Update-side next-entry computation
    // -------------------------------------------------------------------------
    logic [IDX_BITS-1:0] upd_idx;
    logic [TAG_BITS-1:0] upd_tag;
    entry_t              upd_entry;
    logic                upd_hit;
    entry_t              upd_entry_d;
    logic                upd_we;

    assign upd_idx   = upd_pc_i[IDX_MSB:IDX_LSB];
    assign upd_tag   = upd_pc_i[TAG_MSB:TAG_LSB];
    assign upd_entry = entry_q[upd_idx];
    assign upd_hit   = valid_q[upd_idx] && (upd_entry.tag == upd_tag);

    // NOTE: every output of a combinational block gets a default at the top,
    // so no path through the if/else tree leaves it unassigned (no latches).
    always_comb begin
        upd_we      = 1'b0;
        upd_entry_d = upd_entry;

        if (upd_valid_i) begin
            if (upd_hit) begin
                // Train the resident entry.
                upd_we              = 1'b1;
                upd_entry_d.is_jump = upd_is_jump_i;
                if (upd_taken_i) begin
                    upd_entry_d.target = upd_target_i;
                    if (upd_entry.ctr != CTR_MAX) begin
                        upd_entry_d.ctr = upd_entry.ctr + 1'b1;
                    end
                end else if (upd_entry.ctr != CTR_MIN) begin
                    upd_entry_d.ctr = upd_entry.ctr - 1'b1;
                end
            end else if (upd_taken_i) begin
                // Allocate on a taken miss, evicting whatever aliased here.
                // Not-taken misses leave the table alone: predicting
                // fall-through is already what a miss does.
                upd_we              = 1'b1;
                upd_entry_d.tag     = upd_tag;
                upd_entry_d.is_jump = upd_is_jump_i;
                upd_entry_d.ctr     = CTR_WEAK;
                upd_entry_d.target  = upd_target_i;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state for valid bits and performance counters
    // -------------------------------------------------------------------------
    always_comb begin
        valid_d            = valid_q;
        perf_updates_d     = perf_updates_q;
        perf_mispredicts_d = perf_mispredicts_q;

        if (upd_we) begin
            valid_d[upd_idx] = 1'b1;
        end

        // Counters stick at all-ones rather than wrapping, so a long run never
        // reports a misleadingly small number.
        if (upd_valid_i && (perf_updates_q != PERF_MAX)) begin
            perf_updates_d = perf_updates_q + 1'b1;
        end
        if (mispredict_o && (perf_mispredicts_q != PERF_MAX)) begin
            perf_mispredicts_d = perf_mispredicts_q + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples its _d value from before the clock edge.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q            <= '0;
            perf_updates_q     <= '0;
            perf_mispredicts_q <= '0;
        end else begin
            valid_q            <= valid_d;
            perf_updates_q     <= perf_updates_d;
            perf_mispredicts_q <= perf_mispredicts_d;
        end
    end

    // Payload write. Reset wins over a coincident update; the entry would be
    // invalid anyway, but suppressing the write keeps the memory quiet.
    always_ff @(posedge clk_i) begin
        if (upd_we && !reset_i) begin
            entry_q[upd_idx] <= upd_entry_d;
        end
    end

    assign perf_updates_o     = perf_updates_q;
    assign perf_mispredicts_o = perf_mispredicts_q;

    // PC bits outside the index/tag fields take no part in prediction.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc_i[1:0], fetch_pc_i[31:TAG_MSB+1],
                              upd_pc_i[1:0],   upd_pc_i[31:TAG_MSB+1]};

endmodule

// File: tb/tb_otter_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_otter_branch_predictor
//
// Table-driven bench. Each scenario task lists one row per clock cycle: the
// fetch PC, reset, the update-port inputs and the lookup/mispredict outputs
// expected for that cycle. Driving a row pushes its expectation (including the
// perf counter values the bench tracks itself) onto a scoreboard queue; the
// same task pops it at the falling edge and compares it with the DUT outputs.
// The perf counters are built 4 bits wide so their saturation is reachable.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_otter_branch_predictor;

    localparam int PB = 4;
    localparam logic [PB-1:0] PERF_SAT = '1;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic [31:0]   fetch_pc_i;
    logic          pred_hit_o;
    logic          pred_taken_o;
    logic [31:0]   pred_target_o;
    logic          upd_valid_i;
    logic [31:0]   upd_pc_i;
    logic          upd_is_jump_i;
    logic          upd_taken_i;
    logic [31:0]   upd_target_i;
    logic          upd_pred_taken_i;
    logic [31:0]   upd_pred_target_i;
    logic          mispredict_o;
    logic [PB-1:0] perf_updates_o;
    logic [PB-1:0] perf_mispredicts_o;

    otter_branch_predictor #(
        .IDX_BITS (6),
        .TAG_BITS (8),
        .CTR_BITS (2),
        .PERF_BITS(PB)
    ) dut (
        .clk_i             (clk_i),
        .reset_i           (reset_i),
        .fetch_pc_i        (fetch_pc_i),
        .pred_hit_o        (pred_hit_o),
        .pred_taken_o      (pred_taken_o),
        .pred_target_o     (pred_target_o),
        .upd_valid_i       (upd_valid_i),
        .upd_pc_i          (upd_pc_i),
        .upd_is_jump_i     (upd_is_jump_i),
        .upd_taken_i       (upd_taken_i),
        .upd_target_i      (upd_target_i),
        .upd_pred_taken_i  (upd_pred_taken_i),
        .upd_pred_target_i (upd_pred_target_i),
        .mispredict_o      (mispredict_o),
        .perf_updates_o    (perf_updates_o),
        .perf_mispredicts_o(perf_mispredicts_o)
    );

    always #5 clk_i = ~clk_i;

    // Observed vector: {hit, taken, target, mispredict, perf_updates, perf_mispredicts}
    logic [34+2*PB:0] obs;
    assign obs = {pred_hit_o, pred_taken_o, pred_target_o, mispredict_o,
                  perf_updates_o, perf_mispredicts_o};

    typedef struct {
        logic [31:0] fetch;
        logic        rst;
        logic        uv;
        logic [31:0] upc;
        logic        uj;
        logic        ut;
        logic [31:0] utgt;
        logic        upt;
        logic [31:0] uptgt;
        logic        hit;
        logic        tk;
        logic [31:0] tgt;
        logic        misp;
    } stim_t;

    typedef struct {
        string            name;
        int               row;
        logic [34+2*PB:0] v;
    } exp_t;

    exp_t          exp_q[$];
    int            checks = 0;
    int            errors = 0;
    logic [PB-1:0] cnt_upd = '0;
    logic [PB-1:0] cnt_mis = '0;

    function automatic stim_t mk(input logic [31:0] fetch, input int rst, input int uv,
                                 input logic [31:0] upc, input int uj, input int ut,
                                 input logic [31:0] utgt, input int upt,
                                 input logic [31:0] uptgt, input int hit, input int tk,
                                 input logic [31:0] tgt, input int misp);
        stim_t s;
        s.fetch = fetch;    s.rst  = (rst != 0);  s.uv   = (uv != 0);
        s.upc   = upc;      s.uj   = (uj != 0);   s.ut   = (ut != 0);
        s.utgt  = utgt;     s.upt  = (upt != 0);  s.uptgt = uptgt;
        s.hit   = (hit != 0); s.tk = (tk != 0);   s.tgt  = tgt;
        s.misp  = (misp != 0);
        return s;
    endfunction

    // Drive one row and push what the DUT must show for it this cycle. The perf
    // fields are the counts accumulated by earlier rows; this row's effect on
    // them becomes visible one cycle later.
    task automatic apply(input stim_t s, input string name, input int row);
        exp_t e;
        reset_i           = s.rst;
        fetch_pc_i        = s.fetch;
        upd_valid_i       = s.uv;
        upd_pc_i          = s.upc;
        upd_is_jump_i     = s.uj;
        upd_taken_i       = s.ut;
        upd_target_i      = s.utgt;
        upd_pred_taken_i  = s.upt;
        upd_pred_target_i = s.uptgt;
        e.name = name;
        e.row  = row;
        e.v    = {s.hit, s.tk, s.tgt, s.misp, cnt_upd, cnt_mis};
        exp_q.push_back(e);
        if (s.rst) begin
            cnt_upd = '0;
            cnt_mis = '0;
        end else begin
            if (s.uv   && cnt_upd != PERF_SAT) cnt_upd = cnt_upd + 1'b1;
            if (s.misp && cnt_mis != PERF_SAT) cnt_mis = cnt_mis + 1'b1;
        end
    endtask

    // Empty table after reset; fall-through target including 32-bit wrap.
    task automatic test_reset();
        stim_t s[$];
        exp_t  e;
        s.push_back(mk(32'h100,      0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h104, 0));
        s.push_back(mk(32'hFFFFFFFC, 0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0,   0));
        foreach (s[i]) begin
            apply(s[i], "reset", i);
            @(negedge clk_i);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e.v) begin
                errors++;
                $display("FAIL %s[%0d]: got %h want %h (hit,taken,target,misp,perf_upd,perf_mis)",
                         e.name, e.row, obs, e.v);
            end
            @(posedge clk_i); #1;
        end
    endtask

    // Taken update allocates; mispredict flagged in the update cycle.
    task automatic test_allocate();
        stim_t s[$];
        exp_t  e;
        s.push_back(mk(32'h100, 0, 1, 32'h100, 0, 1, 32'h40, 0, 32'h104, 0, 0, 32'h104, 1));
        s.push_back(mk(32'h100, 0, 0, 32'h0,   0, 0, 32'h0,  0, 32'h0,   1, 1, 32'h40,  0));
        foreach (s[i]) begin
            apply(s[i], "allocate", i);
            @(negedge clk_i);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e.v) begin
                errors++;
                $display("FAIL %s[%0d]: got %h want %h (hit,taken,target,misp,perf_upd,perf_mis)",
                         e.name, e.row, obs, e.v);
            end
            @(posedge clk_i); #1;
        end
    endtask

    // Counter 2->1->0->0, back up to 2, then saturate at 3 and step down to 2.
    task automatic test_counter();
        stim_t s[$];
        exp_t  e;
        s.push_back(mk(32'h100, 0, 1, 32'h100, 0, 0, 32'h0,  1, 32'h40,  1, 1, 32'h40,  1));
        s.push_back(mk(32'h100, 0, 1, 32'h100, 0, 0, 32'h0,  0, 32'h104, 1, 0, 32'h104, 0));
        s.push_back(mk(32'h100, 0, 1, 32'h100, 0, 0, 32'h0,  0, 32'h104, 1, 0, 32'h104, 0));
        s.push_back(mk(32'h100, 0, 0, 32'h0,   0, 0, 32'h0,  0, 32'h0,   1, 0, 32'h104, 0));
        s.push_back(mk(32'h100, 0, 1, 32'h100, 0, 1, 32'h40, 0, 32'h104, 1, 0, 32'h104, 1));
        s.push_back(mk(32'h100, 0, 1, 32'h100, 0, 1, 32'h40, 0, 32'h104, 1, 0, 32'h104, 1));
        s.push_back(mk(32'h100, 0, 0, 32'h0,   0, 0, 32'h0,  0, 32'h0,   1, 1, 32'h40,  0));
        s.push_back(mk(32'h100, 0, 1, 32'h100, 0, 1, 32'h40, 1, 32'h40,  1, 1, 32'h40,  0));
        s.push_back(mk(32'h100, 0, 1, 32'h100, 0, 1, 32'h40, 1, 32'h40,  1, 1, 32'h40,  0));
        s.push_back(mk(32'h100, 0, 1, 32'h100, 0, 0, 32'h0,  1, 32'h40,  1, 1, 32'h40,  1));
        s.push_back(mk(32'h100, 0, 0, 32'h0,   0, 0, 32'h0,  0, 32'h0,   1, 1, 32'h40,  0));
        foreach (s[i]) begin
            apply(s[i], "counter", i);
            @(negedge clk_i);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e.v) begin
                errors++;
                $display("FAIL %s[%0d]: got %h want %h (hit,taken,target,misp,perf_upd,perf_mis)",
                         e.name, e.row, obs, e.v);
            end
            @(posedge clk_i); #1;
        end
    endtask

    // Jumps predict taken regardless of counter; low PC bits ignored; a
    // not-taken branch update clears is_jump on the entry.
    task automatic test_jump();
        stim_t s[$];
        exp_t  e;
        s.push_back(mk(32'h200, 0, 1, 32'h200, 1, 1, 32'h80, 0, 32'h204, 0, 0, 32'h204, 1));
        s.push_back(mk(32'h200, 0, 1, 32'h200, 1, 0, 32'h0,  1, 32'h80,  1, 1, 32'h80,  1));
        s.push_back(mk(32'h200, 0, 0, 32'h0,   0, 0, 32'h0,  0, 32'h0,   1, 1, 32'h80,  0));
        s.push_back(mk(32'h203, 0, 0, 32'h0,   0, 0, 32'h0,  0, 32'h0,   1, 1, 32'h80,  0));
        s.push_back(mk(32'h200, 0, 1, 32'h200, 0, 0, 32'h0,  1, 32'h80,  1, 1, 32'h80,  1));
        s.push_back(mk(32'h200, 0, 0, 32'h0,   0, 0, 32'h0,  0, 32'h0,   1, 0, 32'h204, 0));
        foreach (s[i]) begin
            apply(s[i], "jump", i);
            @(negedge clk_i);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e.v) begin
                errors++;
                $display("FAIL %s[%0d]: got %h want %h (hit,taken,target,misp,perf_upd,perf_mis)",
                         e.name, e.row, obs, e.v);
            end
            @(posedge clk_i); #1;
        end
    endtask

    // 0x100/0x200/0x300 share index 0. Taken updates evict; not-taken miss
    // allocates nothing; wrong target with right direction still mispredicts.
    task automatic test_alias();
        stim_t s[$];
        exp_t  e;
        s.push_back(mk(32'h100, 0, 1, 32'h100, 0, 1, 32'h44, 0, 32'h104, 0, 0, 32'h104, 1));
        s.push_back(mk(32'h100, 0, 0, 32'h0,   0, 0, 32'h0,  0, 32'h0,   1, 1, 32'h44,  0));
        s.push_back(mk(32'h200, 0, 0, 32'h0,   0, 0, 32'h0,  0, 32'h0,   0, 0, 32'h204, 0));
        s.push_back(mk(32'h100, 0, 1, 32'h200, 0, 1, 32'h88, 1, 32'h80,  1, 1, 32'h44,  1));
        s.push_back(mk(32'h100, 0, 0, 32'h0,   0, 0, 32'h0,  0, 32'h0,   0, 0, 32'h104, 0));
        s.push_back(mk(32'h200, 0, 0, 32'h0,   0, 0, 32'h0,  0, 32'h0,   1, 1, 32'h88,  0));
        s.push_back(mk(32'h300, 0, 1, 32'h300, 0, 0, 32'h0,  0, 32'h304, 0, 0, 32'h304, 0));
        s.push_back(mk(32'h200, 0, 0, 32'h0,   0, 0, 32'h0,  0, 32'h0,   1, 1, 32'h88,  0));
        s.push_back(mk(32'h300, 0, 0, 32'h0,   0, 0, 32'h0,  0, 32'h0,   0, 0, 32'h304, 0));
        foreach (s[i]) begin
            apply(s[i], "alias", i);
            @(negedge clk_i);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e.v) begin
                errors++;
                $display("FAIL %s[%0d]: got %h want %h (hit,taken,target,misp,perf_upd,perf_mis)",
                         e.name, e.row, obs, e.v);
            end
            @(posedge clk_i); #1;
        end
    endtask

    // Lookup and update of the same index in consecutive cycles: each cycle
    // shows the pre-update entry. Also pushes perf_updates past saturation.
    task automatic test_back_to_back();
        stim_t s[$];
        exp_t  e;
        s.push_back(mk(32'h100, 0, 1, 32'h100, 0, 1, 32'h48, 0, 32'h104, 0, 0, 32'h104, 1));
        s.push_back(mk(32'h100, 0, 1, 32'h100, 0, 1, 32'h4C, 1, 32'h48,  1, 1, 32'h48,  1));
        s.push_back(mk(32'h100, 0, 0, 32'h0,   0, 0, 32'h0,  0, 32'h0,   1, 1, 32'h4C,  0));
        foreach (s[i]) begin
            apply(s[i], "back_to_back", i);
            @(negedge clk_i);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e.v) begin
                errors++;
                $display("FAIL %s[%0d]: got %h want %h (hit,taken,target,misp,perf_upd,perf_mis)",
                         e.name, e.row, obs, e.v);
            end
            @(posedge clk_i); #1;
        end
    endtask

    // Reset with a coincident taken update: mispredict still combinational,
    // afterwards table empty, no allocation, counters zero.
    task automatic test_reset_update();
        stim_t s[$];
        exp_t  e;
        s.push_back(mk(32'h100, 1, 1, 32'h200, 0, 1, 32'h90, 0, 32'h0, 1, 1, 32'h4C,  1));
        s.push_back(mk(32'h100, 0, 0, 32'h0,   0, 0, 32'h0,  0, 32'h0, 0, 0, 32'h104, 0));
        s.push_back(mk(32'h200, 0, 0, 32'h0,   0, 0, 32'h0,  0, 32'h0, 0, 0, 32'h204, 0));
        foreach (s[i]) begin
            apply(s[i], "reset_update", i);
            @(negedge clk_i);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e.v) begin
                errors++;
                $display("FAIL %s[%0d]: got %h want %h (hit,taken,target,misp,perf_upd,perf_mis)",
                         e.name, e.row, obs, e.v);
            end
            @(posedge clk_i); #1;
        end
    endtask

    initial begin
        reset_i           = 1'b1;
        fetch_pc_i        = 32'h0;
        upd_valid_i       = 1'b0;
        upd_pc_i          = 32'h0;
        upd_is_jump_i     = 1'b0;
        upd_taken_i       = 1'b0;
        upd_target_i      = 32'h0;
        upd_pred_taken_i  = 1'b0;
        upd_pred_target_i = 32'h0;
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b0;

        test_reset();
        test_allocate();
        test_counter();
        test_jump();
        test_alias();
        test_back_to_back();
        test_reset_update();

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d expectations left unchecked", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
